sha_padder: RTL and testbench

Message padding stage directly upstream of the W(t) schedule unit. Accepts a raw message as a 64-bit AXI-Stream byte stream with the SHA variant in TUSER. Applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a big-endian bit length. Emits 512-bit beats: one beat per block for SHA-224/256, two beats (left half, then right half) per 1024-bit block for SHA-384/512.

---
 rtl/sha_padder.sv | 175 +++++++++++++++++
 tb/tb_sha_padder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_padder.sv
// sha_padder: FIPS 180-4 padding of a 64-bit AXI-Stream byte message into 512-bit beats (SHA_PADDER_TKEEP_CHECK_EN adds tkeep_err).
// Latency: 1 cycle after a buffer-filling beat, 2 after a short last beat; a stalled output beat holds stable and drops s_axis_tready.
module sha_padder #(
  parameter int S_AXIS_DATA_WIDTH  = 64,
  parameter int M_AXIS_DATA_WIDTH  = 512,
  parameter int S_AXIS_TUSER_WIDTH = 128,
  parameter int M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef SHA_PADDER_TKEEP_CHECK_EN
  ,
  output logic                            tkeep_err
`endif
);

  typedef enum logic [1:0] {IDLE, ABSORB, PAD, EMIT} state_t;
  state_t state, state_n;

  logic [511:0] beat_buf, absorb_buf, pad_buf;
  logic [6:0]   ptr, cur_ptr, ptr_new, pad_q;
  logic [60:0]  msg_len, cur_len, len_new;
  logic [63:0]  len_bits;
  logic [3:0]   n_bytes;
  logic         half, is_b128, mark_done, len_done, pad_pending;
  logic         accept, emit_hs, len_fits;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  assign accept       = s_axis_tvalid & s_axis_tready;
  assign emit_hs      = m_axis_tvalid & m_axis_tready;
  assign n_bytes      = popcount8(s_axis_tkeep);
  assign cur_ptr      = (state == IDLE) ? 7'd0 : ptr;
  assign cur_len      = (state == IDLE) ? 61'd0 : msg_len;
  assign ptr_new      = cur_ptr + {3'b000, n_bytes};
  assign len_new      = cur_len + {57'd0, n_bytes};
  assign m_axis_tdata = beat_buf;

  always_comb begin
    absorb_buf = beat_buf;
    for (int i = 0; i < 8; i++)
      if (s_axis_tkeep[i])
        absorb_buf[{cur_ptr[5:0] + 6'(i), 3'b000} +: 8] = s_axis_tdata[8*i +: 8];
  end

  // Length goes in only on the block-final beat and only if it fits after the marker.
  assign pad_q    = ptr + {6'd0, ~mark_done};
  assign len_bits = {msg_len, 3'b000};
  assign len_fits = (~is_b128 | half) && (pad_q <= (is_b128 ? 7'd48 : 7'd56));

  always_comb begin
    pad_buf = beat_buf;
    for (int k = 0; k < 64; k++) begin
      if (!mark_done && (7'(k) == ptr)) pad_buf[8*k +: 8] = 8'h80;
      else if (7'(k) >= pad_q)          pad_buf[8*k +: 8] = 8'h00;
    end
    if (len_fits)
      for (int j = 0; j < 8; j++)
        pad_buf[8*(56+j) +: 8] = len_bits[8*(7-j) +: 8];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, ABSORB: begin
        if (accept) begin
          if (ptr_new == 7'd64)  state_n = EMIT;
          else if (s_axis_tlast) state_n = PAD;
          else                   state_n = ABSORB;
        end
      end
      PAD: state_n = EMIT;
      EMIT: begin
        if (emit_hs) begin
          if (len_done)         state_n = IDLE;
          else if (pad_pending) state_n = PAD;
          else                  state_n = ABSORB;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      beat_buf      <= '0;
      ptr           <= '0;
      msg_len       <= '0;
      half          <= 1'b0;
      is_b128       <= 1'b0;
      mark_done     <= 1'b0;
      len_done      <= 1'b0;
      pad_pending   <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      s_axis_tready <= (state_n == IDLE) || (state_n == ABSORB);
      m_axis_tvalid <= (state_n == EMIT);
      case (state)
        IDLE, ABSORB: begin
          if (accept) begin
            beat_buf    <= absorb_buf;
            ptr         <= ptr_new;
            msg_len     <= len_new;
            // A last beat that exactly fills the buffer still owes a padding beat.
            pad_pending <= s_axis_tlast && (ptr_new == 7'd64);
            if (state == IDLE) begin
              m_axis_tuser <= s_axis_tuser;
              is_b128      <= s_axis_tuser[33];
              half         <= 1'b0;
              mark_done    <= 1'b0;
              len_done     <= 1'b0;
              m_axis_tlast <= 1'b0;
            end
          end
        end
        PAD: begin
          beat_buf  <= pad_buf;
          mark_done <= 1'b1;
          if (len_fits) begin
            len_done     <= 1'b1;
            m_axis_tlast <= 1'b1;
          end else begin
            pad_pending  <= 1'b1;
          end
        end
        EMIT: begin
          if (emit_hs) begin
            ptr          <= '0;
            pad_pending  <= 1'b0;
            m_axis_tlast <= 1'b0;
            if (is_b128) half <= ~half;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA_PADDER_TKEEP_CHECK_EN
  logic keep_contig;
  assign keep_contig = ((s_axis_tkeep & (s_axis_tkeep + 8'd1)) == 8'd0);

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset)
      tkeep_err <= 1'b0;
    else if (accept && (!keep_contig || (!s_axis_tlast && (s_axis_tkeep != 8'hFF))))
      tkeep_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sha_padder.sv
// Directed bench for sha_padder: hand-computed padded beats plus a byte-level FIPS 180-4 reference,
// covering reset, latency, block boundaries, output stalls and mid-message reset.
module tb_sha_padder;

  logic         axis_aclk = 1'b0;
  logic         axis_reset;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
`ifdef SHA_PADDER_TKEEP_CHECK_EN
  logic         tkeep_err;
`endif

  sha_padder dut (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef SHA_PADDER_TKEEP_CHECK_EN
    ,
    .tkeep_err     (tkeep_err)
`endif
  );

  always #5 axis_aclk = ~axis_aclk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   msg [0:255];
  logic [511:0] exp_q [$];
  logic         exp_last_q [$];
  logic [511:0] rx_q [$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_user(input logic [1:0] t, input logic [63:0] tag);
    logic [127:0] u;
    u = '0;
    u[127:64] = tag;
    u[33:32]  = t;
    u[15:0]   = 16'hBEEF;
    return u;
  endfunction

  function automatic logic [511:0] rx(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return '1;
  endfunction

  task automatic fill_msg(input int seed);
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 37 + seed);
  endtask

  // Reference: message, 0x80, zeros to B-LB mod B, then LB-byte big-endian bit length.
  task automatic build_exp(input int len, input bit b128);
    logic [7:0]   q [$];
    int           blk, lb, nb;
    logic [63:0]  bits;
    logic [511:0] beat;
    blk = b128 ? 128 : 64;
    lb  = b128 ? 16 : 8;
    exp_q.delete(); exp_last_q.delete(); rx_q.delete();
    for (int i = 0; i < len; i++) q.push_back(msg[i]);
    q.push_back(8'h80);
    while ((q.size() % blk) != blk - lb) q.push_back(8'h00);
    for (int i = 0; i < lb - 8; i++) q.push_back(8'h00);
    bits = 64'(len) * 64'd8;
    for (int j = 7; j >= 0; j--) q.push_back(bits[8*j +: 8]);
    nb = q.size() / 64;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int k = 0; k < 64; k++) beat[8*k +: 8] = q[64*b + k];
      exp_q.push_back(beat);
      exp_last_q.push_back(b == nb - 1);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] kp, input logic [127:0] u, input logic last);
    int t;
    t = 0;
    @(negedge axis_aclk);
    s_axis_tdata = d; s_axis_tkeep = kp; s_axis_tuser = u; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && t < 5000) begin
      @(negedge axis_aclk);
      t++;
    end
    if (!s_axis_tready) check("send_timeout", s_axis_tready, 1'b1);
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Later beats carry inverted tuser so only first-beat capture matches.
  task automatic send_msg(input int len, input logic [127:0] user);
    int nb;
    nb = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      int          n;
      logic [63:0] d;
      logic [7:0]  kp;
      n = (b == nb - 1) ? len - 8*b : 8;
      for (int i = 0; i < 8; i++) d[8*i +: 8] = (i < n) ? msg[8*b + i] : 8'hEE;
      kp = 8'((16'd1 << n) - 16'd1);
      send_beat(d, kp, (b == 0) ? user : ~user, b == nb - 1);
    end
  endtask

  task automatic recv(input int nbeats, input int stall, input logic [127:0] user, input string name);
    for (int b = 0; b < nbeats; b++) begin
      int           t;
      logic [511:0] snap;
      logic         snap_last;
      bit           hold_ok;
      t = 0;
      m_axis_tready = (stall == 0);
      @(negedge axis_aclk);
      while (!m_axis_tvalid && t < 2000) begin
        @(negedge axis_aclk);
        t++;
      end
      if (!m_axis_tvalid) begin
        check($sformatf("%s_rx_timeout%0d", name, b), m_axis_tvalid, 1'b1);
        m_axis_tready = 1'b0;
        return;
      end
      snap = m_axis_tdata; snap_last = m_axis_tlast; hold_ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge axis_aclk);
        if (m_axis_tdata !== snap || m_axis_tlast !== snap_last || m_axis_tuser !== user ||
            m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) hold_ok = 1'b0;
      end
      if (stall > 0) begin
        check($sformatf("%s_stall_hold%0d", name, b), hold_ok, 1'b1);
        m_axis_tready = 1'b1;
      end
      rx_q.push_back(m_axis_tdata);
      check($sformatf("%s_data%0d", name, b), m_axis_tdata, exp_q[b]);
      check($sformatf("%s_last%0d", name, b), m_axis_tlast, exp_last_q[b]);
      check($sformatf("%s_user%0d", name, b), m_axis_tuser, user);
      @(posedge axis_aclk);
      #1;
      m_axis_tready = 1'b0;
    end
  endtask

  task automatic no_extra(input string name);
    int extra;
    extra = 0;
    m_axis_tready = 1'b1;
    repeat (20) begin
      @(negedge axis_aclk);
      if (m_axis_tvalid) extra++;
    end
    m_axis_tready = 1'b0;
    check({name, "_extra_beats"}, extra, 0);
  endtask

  // Edges from the accepting edge until m_axis_tvalid is seen high.
  task automatic lat_check(input string tag, input int exp_k);
    int k;
    k = 1;
    while (!m_axis_tvalid && k < 50) begin
      @(posedge axis_aclk);
      #1;
      k++;
    end
    check(tag, k, exp_k);
  endtask

  task automatic run_msg(input string name, input int len, input logic [1:0] t, input int stall);
    logic [127:0] u;
    u = mk_user(t, 64'(len) ^ 64'hC0DE_0000_0000_0000);
    build_exp(len, t[1]);
    fork
      send_msg(len, u);
      recv(exp_q.size(), stall, u, name);
    join
    no_extra(name);
  endtask

  task automatic run_abc(input string name);
    logic [127:0] u;
    logic [511:0] hand;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    u = mk_user(2'd1, 64'h0000_0000_0061_6263);
    build_exp(3, 1'b0);
    send_msg(3, u);
    lat_check({name, "_latency"}, 2);
    recv(1, 0, u, name);
    hand = '0;
    hand[31:0]    = 32'h8063_6261;
    hand[511:504] = 8'h18;
    check({name, "_hand"}, rx(0), hand);
    no_extra(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [511:0] hand;
    logic [127:0] u;
    axis_reset = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast",  m_axis_tlast,  1'b0);
    check("rst_tdata",  m_axis_tdata,  '0);
    check("rst_tuser",  m_axis_tuser,  '0);
    axis_reset = 1'b0;
    #1;
    check("rdy_before_edge", s_axis_tready, 1'b0);
    @(posedge axis_aclk);
    #1;
    check("rdy_rise", s_axis_tready, 1'b1);

    run_abc("abc");

    run_msg("empty512", 0, 2'd3, 0);
    check("empty512_hand0", rx(0), 512'h80);
    check("empty512_hand1", rx(1), 512'h0);

    fill_msg(11);
    run_msg("m56", 56, 2'd1, 0);
    check("m56_marker", rx(0)[511:448], 64'h80);
    hand = '0;
    hand[503:496] = 8'h01;
    hand[511:504] = 8'hC0;
    check("m56_hand1", rx(1), hand);

    fill_msg(23);
    u = mk_user(2'd0, 64'h64);
    build_exp(64, 1'b0);
    send_msg(64, u);
    lat_check("m64_latency", 1);
    recv(2, 0, u, "m64");
    hand = '0;
    hand[7:0]     = 8'h80;
    hand[503:496] = 8'h02;
    hand[511:504] = 8'h00;
    check("m64_hand1", rx(1), hand);
    no_extra("m64");

    fill_msg(5);
    run_msg("stall100", 100, 2'd1, 10);
    check("stall100_len_bytes", rx(1)[511:496], 16'h2003);

    fill_msg(41);
    run_msg("m55", 55, 2'd1, 0);
    run_msg("m111_384", 111, 2'd2, 0);
    run_msg("m112_512", 112, 2'd3, 0);

    fill_msg(77);
    u = mk_user(2'd1, 64'hDEAD);
    for (int b = 0; b < 3; b++)
      send_beat({msg[8*b+7], msg[8*b+6], msg[8*b+5], msg[8*b+4],
                 msg[8*b+3], msg[8*b+2], msg[8*b+1], msg[8*b]}, 8'hFF, u, 1'b0);
    #3 axis_reset = 1'b1;
    #1;
    check("midrst_tready", s_axis_tready, 1'b0);
    check("midrst_tdata",  m_axis_tdata,  '0);
    check("midrst_tuser",  m_axis_tuser,  '0);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    run_abc("rst_abc");

`ifdef SHA_PADDER_TKEEP_CHECK_EN
    check("kerr_clear", tkeep_err, 1'b0);
    u = mk_user(2'd1, 64'hBAD);
    send_beat(64'h0000_0000_0403_0201, 8'h0F, u, 1'b0);
    send_beat(64'h0, 8'h00, ~u, 1'b1);
    check("kerr_set", tkeep_err, 1'b1);
    m_axis_tready = 1'b1;
    repeat (10) @(posedge axis_aclk);
    #1;
    m_axis_tready = 1'b0;
    check("kerr_sticky", tkeep_err, 1'b1);
    axis_reset = 1'b1;
    #1;
    check("kerr_reset", tkeep_err, 1'b0);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
